// File: rtl/axis_upsizer_64_to_256.sv
// AXI4-Stream width upconverter: packs RATIO narrow beats into one wide word.
// A single output register decouples back-pressure; id/dest changes flush a partial word.
module axis_upsizer_64_to_256 #(
  parameter int IN_W   = 64,
  parameter int RATIO  = 4,
  parameter int ID_W   = 4,
  parameter int DEST_W = 4,
  parameter int USER_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [IN_W-1:0]          s_tdata,
  input  logic [IN_W/8-1:0]        s_tstrb,
  input  logic [IN_W/8-1:0]        s_tkeep,
  input  logic                     s_tlast,
  input  logic [ID_W-1:0]          s_tid,
  input  logic [DEST_W-1:0]        s_tdest,
  input  logic [USER_W-1:0]        s_tuser,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [IN_W*RATIO-1:0]    m_tdata,
  output logic [IN_W*RATIO/8-1:0]  m_tstrb,
  output logic [IN_W*RATIO/8-1:0]  m_tkeep,
  output logic                     m_tlast,
  output logic [ID_W-1:0]          m_tid,
  output logic [DEST_W-1:0]        m_tdest,
  output logic [USER_W*RATIO-1:0]  m_tuser
);
  localparam int OUT_W  = IN_W * RATIO;
  localparam int IN_B   = IN_W / 8;
  localparam int OUT_B  = OUT_W / 8;
  localparam int OUT_U  = USER_W * RATIO;
  localparam int SLOT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              partial_q, partial_d;
  logic [OUT_W-1:0]  acc_data_q, acc_data_d;
  logic [OUT_B-1:0]  acc_strb_q, acc_strb_d;
  logic [OUT_B-1:0]  acc_keep_q, acc_keep_d;
  logic [OUT_U-1:0]  acc_user_q, acc_user_d;
  logic [ID_W-1:0]   acc_id_q, acc_id_d;
  logic [DEST_W-1:0] acc_dest_q, acc_dest_d;

  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic [OUT_B-1:0]  out_strb_q, out_strb_d;
  logic [OUT_B-1:0]  out_keep_q, out_keep_d;
  logic              out_last_q, out_last_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic [DEST_W-1:0] out_dest_q, out_dest_d;
  logic [OUT_U-1:0]  out_user_q, out_user_d;

  logic [OUT_W-1:0]  mrg_data;
  logic [OUT_B-1:0]  mrg_strb;
  logic [OUT_B-1:0]  mrg_keep;
  logic [OUT_U-1:0]  mrg_user;

  logic out_free;
  logic completes;
  logic id_change;
  logic accept;
  logic flush;

  // Accumulator contents with the current beat dropped into its slot.
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
      logic lane_hit;
      assign lane_hit = (slot_q == SLOT_W'(gi));
      assign mrg_data[gi*IN_W   +: IN_W]   = lane_hit ? s_tdata : acc_data_q[gi*IN_W   +: IN_W];
      assign mrg_strb[gi*IN_B   +: IN_B]   = lane_hit ? s_tstrb : acc_strb_q[gi*IN_B   +: IN_B];
      assign mrg_keep[gi*IN_B   +: IN_B]   = lane_hit ? s_tkeep : acc_keep_q[gi*IN_B   +: IN_B];
      assign mrg_user[gi*USER_W +: USER_W] = lane_hit ? s_tuser : acc_user_q[gi*USER_W +: USER_W];
    end
  endgenerate

  assign out_free  = !out_valid_q || m_tready;
  assign completes = (slot_q == SLOT_W'(RATIO - 1)) || s_tlast;
  assign id_change = partial_q && s_tvalid &&
                     ((s_tid != acc_id_q) || (s_tdest != acc_dest_q));
  assign s_tready  = !rst && !id_change && !(completes && !out_free);
  assign accept    = s_tvalid && s_tready;
  // A flush steals the cycle; the id-switching beat waits for the next one.
  assign flush     = !rst && id_change && out_free;

  always_comb begin
    slot_d      = slot_q;
    partial_d   = partial_q;
    acc_data_d  = acc_data_q;
    acc_strb_d  = acc_strb_q;
    acc_keep_d  = acc_keep_q;
    acc_user_d  = acc_user_q;
    acc_id_d    = acc_id_q;
    acc_dest_d  = acc_dest_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_strb_d  = out_strb_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_id_d    = out_id_q;
    out_dest_d  = out_dest_q;
    out_user_d  = out_user_q;

    if (out_valid_q && m_tready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (!partial_q) begin
        acc_id_d   = s_tid;
        acc_dest_d = s_tdest;
      end
      if (completes) begin
        out_valid_d = 1'b1;
        out_data_d  = mrg_data;
        out_strb_d  = mrg_strb;
        out_keep_d  = mrg_keep;
        out_user_d  = mrg_user;
        out_last_d  = s_tlast;
        out_id_d    = partial_q ? acc_id_q : s_tid;
        out_dest_d  = partial_q ? acc_dest_q : s_tdest;
        slot_d      = '0;
        partial_d   = 1'b0;
        acc_data_d  = '0;
        acc_strb_d  = '0;
        acc_keep_d  = '0;
        acc_user_d  = '0;
      end else begin
        slot_d      = slot_q + SLOT_W'(1);
        partial_d   = 1'b1;
        acc_data_d  = mrg_data;
        acc_strb_d  = mrg_strb;
        acc_keep_d  = mrg_keep;
        acc_user_d  = mrg_user;
      end
    end else if (flush) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_data_q;
      out_strb_d  = acc_strb_q;
      out_keep_d  = acc_keep_q;
      out_user_d  = acc_user_q;
      out_last_d  = 1'b0;
      out_id_d    = acc_id_q;
      out_dest_d  = acc_dest_q;
      slot_d      = '0;
      partial_d   = 1'b0;
      acc_data_d  = '0;
      acc_strb_d  = '0;
      acc_keep_d  = '0;
      acc_user_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q      <= '0;
      partial_q   <= 1'b0;
      acc_data_q  <= '0;
      acc_strb_q  <= '0;
      acc_keep_q  <= '0;
      acc_user_q  <= '0;
      acc_id_q    <= '0;
      acc_dest_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_id_q    <= '0;
      out_dest_q  <= '0;
      out_user_q  <= '0;
    end else begin
      slot_q      <= slot_d;
      partial_q   <= partial_d;
      acc_data_q  <= acc_data_d;
      acc_strb_q  <= acc_strb_d;
      acc_keep_q  <= acc_keep_d;
      acc_user_q  <= acc_user_d;
      acc_id_q    <= acc_id_d;
      acc_dest_q  <= acc_dest_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_strb_q  <= out_strb_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_id_q    <= out_id_d;
      out_dest_q  <= out_dest_d;
      out_user_q  <= out_user_d;
    end
  end

  assign m_tvalid = out_valid_q;
  assign m_tdata  = out_data_q;
  assign m_tstrb  = out_strb_q;
  assign m_tkeep  = out_keep_q;
  assign m_tlast  = out_last_q;
  assign m_tid    = out_id_q;
  assign m_tdest  = out_dest_q;
  assign m_tuser  = out_user_q;
endmodule

// File: tb/tb_axis_upsizer_64_to_256.sv
// Directed bench for the 64->256 stream upsizer; one line per received word.
module tb_axis_upsizer_64_to_256;
  logic         clk = 1'b0;
  logic         rst;
  logic         s_tvalid;
  logic         s_tready;
  logic [63:0]  s_tdata;
  logic [7:0]   s_tstrb;
  logic [7:0]   s_tkeep;
  logic         s_tlast;
  logic [3:0]   s_tid;
  logic [3:0]   s_tdest;
  logic [3:0]   s_tuser;
  logic         m_tvalid;
  logic         m_tready;
  logic [255:0] m_tdata;
  logic [31:0]  m_tstrb;
  logic [31:0]  m_tkeep;
  logic         m_tlast;
  logic [3:0]   m_tid;
  logic [3:0]   m_tdest;
  logic [15:0]  m_tuser;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic [15:0]  user;
    logic         last;
    logic [3:0]   id;
  } word_t;
  word_t mon_q[$];

  axis_upsizer_64_to_256 dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser)
  );

  always #5 clk = ~clk;

  // Handshake happens at the following posedge; values are stable at negedge.
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      word_t w;
      w.data = m_tdata; w.keep = m_tkeep; w.user = m_tuser;
      w.last = m_tlast; w.id = m_tid;
      mon_q.push_back(w);
      $display("word %0d: data=%h keep=%h user=%h last=%0d id=%0d",
               mon_q.size(), m_tdata, m_tkeep, m_tuser, m_tlast, m_tid);
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic [3:0] u,
                      input logic l, input logic [3:0] id, output int stalls);
    bit done;
    s_tvalid = 1'b1; s_tdata = d; s_tstrb = k; s_tkeep = k;
    s_tuser = u; s_tlast = l; s_tid = id; s_tdest = 4'd0;
    stalls = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if (s_tready) done = 1;
      else begin
        stalls++;
        if (stalls >= 20) begin
          chk("send_timeout", 256'(stalls), 256'd0);
          done = 1;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int st;
    int tot_st;
    logic [255:0] exp_d;
    logic [255:0] held;
    logic [15:0]  exp_u;

    rst = 1'b1; m_tready = 1'b1; s_tdata = '0; s_tstrb = '0; s_tkeep = '0;
    s_tid = '0; s_tdest = '0; s_tuser = '0;
    idle();
    cycles(3);
    @(negedge clk);
    chk("rst_s_tready", 256'(s_tready), 256'd0);
    chk("rst_m_tvalid", 256'(m_tvalid), 256'd0);
    chk("rst_m_tdata", m_tdata, 256'd0);
    chk("rst_m_tkeep", 256'(m_tkeep), 256'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycles(1);
    chk("post_rst_s_tready", 256'(s_tready), 256'd1);

    // Full 4-beat word
    send({8{8'h11}}, 8'hFF, 4'd1, 1'b0, 4'd0, st);
    send({8{8'h22}}, 8'hFF, 4'd2, 1'b0, 4'd0, st);
    send({8{8'h33}}, 8'hFF, 4'd3, 1'b0, 4'd0, st);
    chk("full_no_early_valid", 256'(m_tvalid), 256'd0);
    send({8{8'h44}}, 8'hFF, 4'd4, 1'b1, 4'd0, st);
    idle();
    chk("full_valid_latency", 256'(m_tvalid), 256'd1);
    chk("full_data", m_tdata, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}});
    chk("full_keep", 256'(m_tkeep), 256'hFFFF_FFFF);
    chk("full_user", 256'(m_tuser), 256'h4321);
    chk("full_last", 256'(m_tlast), 256'd1);
    cycles(2);

    // Short packet: tlast on beat 2
    send({8{8'hAA}}, 8'hFF, 4'd5, 1'b0, 4'd0, st);
    send({8{8'hBB}}, 8'hFF, 4'd6, 1'b1, 4'd0, st);
    idle();
    chk("short_valid", 256'(m_tvalid), 256'd1);
    chk("short_keep", 256'(m_tkeep), 256'h0000_FFFF);
    chk("short_data", m_tdata, {128'd0, {8{8'hBB}}, {8{8'hAA}}});
    chk("short_user", 256'(m_tuser), 256'h0065);
    chk("short_last", 256'(m_tlast), 256'd1);
    cycles(2);

    // Back-pressure: 12 beats with the sink stalled
    mon_q.delete();
    m_tready = 1'b0;
    tot_st = 0;
    for (int i = 0; i < 7; i++) begin
      send(64'h1000 + 64'(i), 8'hFF, 4'(i), 1'b0, 4'd0, st);
      tot_st += st;
    end
    chk("bp_first7_no_stall", 256'(tot_st), 256'd0);
    held = m_tdata;
    s_tdata = 64'h1007; s_tuser = 4'd7;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_beat8_stalled", 256'(s_tready), 256'd0);
      chk("bp_word1_stable", m_tdata, held);
      @(posedge clk); #1;
    end
    chk("bp_word1_content", held, {64'h1003, 64'h1002, 64'h1001, 64'h1000});
    m_tready = 1'b1;
    for (int i = 7; i < 12; i++) send(64'h1000 + 64'(i), 8'hFF, 4'(i), 1'b0, 4'd0, st);
    idle();
    cycles(4);
    chk("bp_word_count", 256'(mon_q.size()), 256'd3);
    for (int w = 0; w < 3 && w < mon_q.size(); w++) begin
      for (int k = 0; k < 4; k++) begin
        exp_d[64*k +: 64] = 64'h1000 + 64'(4*w + k);
        exp_u[4*k +: 4]   = 4'(4*w + k);
      end
      chk($sformatf("bp_word%0d_data", w), mon_q[w].data, exp_d);
      chk($sformatf("bp_word%0d_user", w), 256'(mon_q[w].user), 256'(exp_u));
      chk($sformatf("bp_word%0d_last", w), 256'(mon_q[w].last), 256'd0);
    end

    // id switch mid-word
    mon_q.delete();
    send(64'hA1, 8'hFF, 4'd1, 1'b0, 4'd1, st);
    send(64'hA2, 8'hFF, 4'd2, 1'b0, 4'd1, st);
    send(64'hB1, 8'hFF, 4'd3, 1'b1, 4'd2, st);
    idle();
    chk("id_flush_stall", 256'(st), 256'd1);
    cycles(3);
    chk("id_word_count", 256'(mon_q.size()), 256'd2);
    if (mon_q.size() >= 2) begin
      chk("id_w0_tid", 256'(mon_q[0].id), 256'd1);
      chk("id_w0_keep", 256'(mon_q[0].keep), 256'h0000_FFFF);
      chk("id_w0_last", 256'(mon_q[0].last), 256'd0);
      chk("id_w0_data", mon_q[0].data, {128'd0, 64'hA2, 64'hA1});
      chk("id_w1_tid", 256'(mon_q[1].id), 256'd2);
      chk("id_w1_keep", 256'(mon_q[1].keep), 256'h0000_00FF);
      chk("id_w1_data", mon_q[1].data, {192'd0, 64'hB1});
      chk("id_w1_last", 256'(mon_q[1].last), 256'd1);
    end

    // Throughput: 40 back-to-back beats
    mon_q.delete();
    tot_st = 0;
    for (int i = 0; i < 40; i++) begin
      send(64'h2000 + 64'(i), 8'hFF, 4'(i), 1'b0, 4'd3, st);
      tot_st += st;
    end
    idle();
    cycles(3);
    chk("tp_no_stall", 256'(tot_st), 256'd0);
    chk("tp_word_count", 256'(mon_q.size()), 256'd10);
    if (mon_q.size() == 10)
      chk("tp_last_word_data", mon_q[9].data, {64'h2027, 64'h2026, 64'h2025, 64'h2024});

    // Reset mid-word
    mon_q.delete();
    for (int i = 0; i < 3; i++) send(64'hDEAD0 + 64'(i), 8'hFF, 4'd9, 1'b0, 4'd0, st);
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_s_tready", 256'(s_tready), 256'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycles(2);
    chk("midrst_no_valid", 256'(m_tvalid), 256'd0);
    chk("midrst_no_word", 256'(mon_q.size()), 256'd0);
    for (int i = 0; i < 4; i++) send(64'hE0 + 64'(i), 8'hFF, 4'(i), i == 3, 4'd0, st);
    idle();
    cycles(3);
    chk("midrst_word_count", 256'(mon_q.size()), 256'd1);
    if (mon_q.size() >= 1) begin
      chk("midrst_data", mon_q[0].data, {64'hE3, 64'hE2, 64'hE1, 64'hE0});
      chk("midrst_keep", 256'(mon_q[0].keep), 256'hFFFF_FFFF);
      chk("midrst_user", 256'(mon_q[0].user), 256'h3210);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
